// File: rtl/client.sv
// Client ingress block: buffers host operand words in a first-word-fall-through FIFO
// and re-emits them as AXI-Stream beats tagged for the adder node.
module client #(
   parameter int DATAW         = 128,
   parameter int FIFO_DEPTH    = 16,
   parameter int ADDER_NODE_ID = 0,
   parameter int DESTW         = 4,
   parameter int IDW           = 32,
   parameter int STRBW         = 8,
   parameter int KEEPW         = 8,
   parameter int USERW         = 66
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DATAW-1:0] client_tdata,
   input  logic             client_tlast,
   input  logic             client_valid,
   input  logic             axis_client_interface_tready,
   output logic             client_ready,
   output logic             axis_client_interface_tvalid,
   output logic             axis_client_interface_tlast,
   output logic [DESTW-1:0] axis_client_interface_tdest,
   output logic [IDW-1:0]   axis_client_interface_tid,
   output logic [STRBW-1:0] axis_client_interface_tstrb,
   output logic [KEEPW-1:0] axis_client_interface_tkeep,
   output logic [USERW-1:0] axis_client_interface_tuser,
   output logic [DATAW-1:0] axis_client_interface_tdata
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATAW + 1;
   localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]    CNT_ONE = CW'(1);
   localparam logic [AW-1:0]    PTR_ONE = AW'(1);
   localparam logic [IDW-1:0]   TID_ONE = IDW'(1);
   localparam logic [DESTW-1:0] DEST_C  = DESTW'(ADDER_NODE_ID);

   logic [EW-1:0]  mem_r [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_r;
   logic [AW-1:0]  rd_ptr_r;
   logic [CW-1:0]  count_r;
   logic           ready_r;
   logic           tvalid_r;
   logic [EW-1:0]  head_r;
   logic [IDW-1:0] tid_r;

   logic           push_s;
   logic           pop_s;
   logic [AW-1:0]  wr_ptr_nxt_s;
   logic [AW-1:0]  rd_ptr_nxt_s;
   logic [CW-1:0]  count_nxt_s;
   logic [EW-1:0]  head_nxt_s;

   assign push_s = client_valid & ready_r;
   assign pop_s  = tvalid_r & axis_client_interface_tready;

   // Next pointer/count state and the head entry to present after this edge.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      count_nxt_s  = count_r;
      head_nxt_s   = {EW{1'b0}};
      if (push_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
      // The new head may be the word being written this very edge (empty or one-deep streaming).
      if (count_nxt_s == {CW{1'b0}}) begin
         head_nxt_s = {EW{1'b0}};
      end else if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
         head_nxt_s = {client_tlast, client_tdata};
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {client_tlast, client_tdata};
      end
   end

   // Pointer, occupancy, registered handshake outputs and packet-ID state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         ready_r  <= 1'b0;
         tvalid_r <= 1'b0;
         head_r   <= {EW{1'b0}};
         tid_r    <= {IDW{1'b0}};
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         count_r  <= count_nxt_s;
         ready_r  <= (count_nxt_s < DEPTH_C);
         tvalid_r <= (count_nxt_s != {CW{1'b0}});
         head_r   <= head_nxt_s;
         if (pop_s && head_r[DATAW]) begin
            tid_r <= tid_r + TID_ONE;
         end
      end
   end

   assign client_ready                 = ready_r;
   assign axis_client_interface_tvalid = tvalid_r;
   assign axis_client_interface_tlast  = head_r[DATAW];
   assign axis_client_interface_tdata  = head_r[DATAW-1:0];
   assign axis_client_interface_tid    = tid_r;
   assign axis_client_interface_tdest  = rst ? DEST_C : {DESTW{1'b0}};
   assign axis_client_interface_tstrb  = rst ? {STRBW{1'b1}} : {STRBW{1'b0}};
   assign axis_client_interface_tkeep  = rst ? {KEEPW{1'b1}} : {KEEPW{1'b0}};
   assign axis_client_interface_tuser  = {USERW{1'b0}};

endmodule

// File: tb/tb_client.sv
// Self-checking bench for client: table-driven packets plus hand-written backpressure,
// streaming and mid-packet reset sequences, all checked against a scoreboard model.
module tb_client;
   localparam int DATAW      = 128;
   localparam int FIFO_DEPTH = 16;
   localparam int DESTW      = 4;
   localparam int IDW        = 32;
   localparam int STRBW      = 8;
   localparam int KEEPW      = 8;
   localparam int USERW      = 66;

   logic             clk = 1'b0;
   logic             rst;
   logic [DATAW-1:0] client_tdata;
   logic             client_tlast;
   logic             client_valid;
   logic             tready;
   logic             client_ready;
   logic             tvalid;
   logic             tlast;
   logic [DESTW-1:0] tdest;
   logic [IDW-1:0]   tid;
   logic [STRBW-1:0] tstrb;
   logic [KEEPW-1:0] tkeep;
   logic [USERW-1:0] tuser;
   logic [DATAW-1:0] tdata;

   always #5 clk = ~clk;

   client #(.DATAW(DATAW), .FIFO_DEPTH(FIFO_DEPTH), .ADDER_NODE_ID(0), .DESTW(DESTW),
            .IDW(IDW), .STRBW(STRBW), .KEEPW(KEEPW), .USERW(USERW)) dut (
      .clk(clk), .rst(rst),
      .client_tdata(client_tdata), .client_tlast(client_tlast), .client_valid(client_valid),
      .axis_client_interface_tready(tready),
      .client_ready(client_ready),
      .axis_client_interface_tvalid(tvalid), .axis_client_interface_tlast(tlast),
      .axis_client_interface_tdest(tdest), .axis_client_interface_tid(tid),
      .axis_client_interface_tstrb(tstrb), .axis_client_interface_tkeep(tkeep),
      .axis_client_interface_tuser(tuser), .axis_client_interface_tdata(tdata)
   );

   typedef struct {
      logic             v;
      logic             l;
      logic [DATAW-1:0] d;
      logic             tr;
      logic             exp_ready;
      logic             exp_tvalid;
   } vec_t;

   typedef struct {
      logic             last;
      logic [DATAW-1:0] data;
      logic [IDW-1:0]   id;
   } sb_t;

   sb_t            sb_q[$];
   vec_t           vecs[10];
   int             checks = 0;
   int             errors = 0;
   int             model_count;
   logic           model_ready;
   logic [IDW-1:0] tid_push;

   task automatic chk(input string name, input logic [DATAW+3:0] act, input logic [DATAW+3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      model_count = 0;
      model_ready = 1'b0;
      tid_push    = '0;
   endtask

   // One clock cycle: drive, compare at the falling edge, update model, advance past the rising edge.
   task automatic cycle(input logic v, input logic l, input logic [DATAW-1:0] d, input logic tr,
                        input logic exp_en, input logic exp_ready, input logic exp_tvalid);
      sb_t  e;
      logic push_m;
      logic pop_m;
      client_valid = v;
      client_tlast = l;
      client_tdata = d;
      tready       = tr;
      @(negedge clk);
      chk("client_ready", client_ready, model_ready);
      chk("tvalid", tvalid, model_count != 0);
      if (exp_en) begin
         chk("tbl_ready", client_ready, exp_ready);
         chk("tbl_tvalid", tvalid, exp_tvalid);
      end
      push_m = v && model_ready;
      pop_m  = (model_count != 0) && tr;
      if (model_count != 0 && sb_q.size() > 0) begin
         e = sb_q[0];
         chk("tdata", tdata, e.data);
         chk("tlast", tlast, e.last);
         chk("tid", tid, e.id);
         chk("tdest", tdest, 4'd0);
         chk("tstrb", tstrb, 8'hFF);
         chk("tkeep", tkeep, 8'hFF);
         chk("tuser", tuser, 66'd0);
         if (pop_m) void'(sb_q.pop_front());
      end else begin
         chk("idle_tdata", tdata, 128'd0);
         chk("idle_tlast", tlast, 1'b0);
      end
      if (push_m) begin
         sb_q.push_back('{l, d, tid_push});
         if (l) tid_push = tid_push + 32'd1;
      end
      model_count = model_count + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      @(posedge clk);
      #1;
      model_ready = rst && (model_count < FIFO_DEPTH);
   endtask

   initial begin
      // Packet table: idle after release, three-beat packet, then two-beat packet.
      vecs[0] = '{1'b0, 1'b0, 128'd0,  1'b1, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 128'd1,  1'b1, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 128'd2,  1'b1, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 1'b1, 128'd3,  1'b1, 1'b1, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 128'd0,  1'b1, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 128'd0,  1'b1, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 128'd10, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{1'b1, 1'b1, 128'd11, 1'b1, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 128'd0,  1'b1, 1'b1, 1'b1};
      vecs[9] = '{1'b0, 1'b0, 128'd0,  1'b1, 1'b1, 1'b0};

      rst = 1'b0;
      client_valid = 1'b0;
      client_tlast = 1'b0;
      client_tdata = '0;
      tready = 1'b0;
      model_reset();
      #1;
      cycle(1'b0, 1'b0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_ready", client_ready, 1'b0);
      chk("rst_tvalid", tvalid, 1'b0);
      chk("rst_tdata", tdata, 128'd0);
      chk("rst_tid", tid, 32'd0);
      chk("rst_tdest", tdest, 4'd0);
      chk("rst_tstrb", tstrb, 8'h00);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].tr, 1'b1, vecs[i].exp_ready, vecs[i].exp_tvalid);
      end
      chk("tid_after_two_pkts", tid, 32'd2);

      // Backpressure: fill all 16 entries, offer a 17th, then drain in order.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         cycle(1'b1, (i == FIFO_DEPTH - 1), DATAW'(i), 1'b0, 1'b1, 1'b1, (i != 0));
      end
      cycle(1'b1, 1'b0, 128'd99, 1'b0, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 2; i < FIFO_DEPTH; i++) begin
         cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("tid_after_full", tid, 32'd3);

      // Steady streaming: one-deep pass-through with no bubbles.
      for (int i = 0; i < 24; i++) begin
         cycle(1'b1, (i % 4 == 3), 128'd1000 + DATAW'(i), 1'b1, 1'b1, 1'b1, (i != 0));
      end
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("tid_after_stream", tid, 32'd9);

      // Mid-packet reset: two of three beats buffered under stall, then flush.
      cycle(1'b1, 1'b0, 128'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 128'h66, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      chk("mid_rst_tvalid", tvalid, 1'b0);
      chk("mid_rst_ready", client_ready, 1'b0);
      chk("mid_rst_tdata", tdata, 128'd0);
      chk("mid_rst_tid", tid, 32'd0);
      model_reset();
      cycle(1'b1, 1'b1, 128'h77, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 128'h88, 1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 128'd0, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("tid_after_reset_pkt", tid, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
